// File: rtl/adg_pkg.sv
// Shared ADG711 definitions: sequencer state encoding and default phase timings.
package adg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_MAKE  = 2'd2
    } adg_state_e;

    localparam int unsigned ADG_N_SW       = 4;
    localparam int unsigned ADG_DEAD_CYC   = 8;
    localparam int unsigned ADG_SETTLE_CYC = 50;
    localparam int unsigned ADG_CNT_W      = 11;

endpackage

// File: rtl/adg_phase_cnt.sv
// Loadable down-counter timing the break and make phases; zero flag is registered.
module adg_phase_cnt #(
    parameter int unsigned CNT_W = 11
) (
    input  logic             CP,
    input  logic             CR,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             zero_q;

    // Load wins over decrement; counter parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/adg_switch_seq.sv
// Break-before-make sequencer for the four ADG711 IN lines, with a settled pulse
// once the new mask has been applied for the settle interval.
module adg_switch_seq
    import adg_pkg::*;
#(
    parameter int unsigned N_SW       = ADG_N_SW,
    parameter int unsigned DEAD_CYC   = ADG_DEAD_CYC,
    parameter int unsigned SETTLE_CYC = ADG_SETTLE_CYC,
    parameter int unsigned CNT_W      = ADG_CNT_W
) (
    input  logic            CP,
    input  logic            CR,
    input  logic            req_valid,
    input  logic [N_SW-1:0] req_mask,
    output logic            req_ready,
    output logic [N_SW-1:0] sw_in,
    output logic            busy,
    output logic            settled
);

    adg_state_e      state_q;
    logic [N_SW-1:0] cur_q;
    logic [N_SW-1:0] nxt_q;
    logic [N_SW-1:0] sw_q;
    logic            busy_q;
    logic            settled_q;

    logic             accept_c;
    logic             conflict_c;
    logic             cnt_zero;
    logic             cnt_load_c;
    logic             cnt_en_c;
    logic [CNT_W-1:0] cnt_val_c;

    assign req_ready = (state_q == ST_IDLE) && !CR;
    assign accept_c  = req_valid && req_ready;

    // A break phase is needed only when some switches open while others close.
    assign conflict_c = (|(req_mask & ~cur_q)) && (|(cur_q & ~req_mask));

    assign cnt_load_c = accept_c || ((state_q == ST_BREAK) && cnt_zero);
    assign cnt_val_c  = (accept_c && conflict_c) ? CNT_W'(DEAD_CYC - 1)
                                                 : CNT_W'(SETTLE_CYC - 1);
    assign cnt_en_c   = (state_q != ST_IDLE);

    adg_phase_cnt #(
        .CNT_W(CNT_W)
    ) u_phase_cnt (
        .CP        (CP),
        .CR        (CR),
        .load_i    (cnt_load_c),
        .load_val_i(cnt_val_c),
        .en_i      (cnt_en_c),
        .zero_o    (cnt_zero)
    );

    always_ff @(posedge CP) begin
        if (CR) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            nxt_q     <= '0;
            sw_q      <= '0;
            busy_q    <= 1'b0;
            settled_q <= 1'b0;
        end else begin
            settled_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        nxt_q  <= req_mask;
                        busy_q <= 1'b1;
                        if (conflict_c) begin
                            state_q <= ST_BREAK;
                            sw_q    <= cur_q & req_mask;
                        end else begin
                            state_q <= ST_MAKE;
                            sw_q    <= req_mask;
                        end
                    end
                end
                ST_BREAK: begin
                    if (cnt_zero) begin
                        state_q <= ST_MAKE;
                        sw_q    <= nxt_q;
                    end
                end
                ST_MAKE: begin
                    // Commit the mask; the settled pulse lands on the first idle cycle.
                    if (cnt_zero) begin
                        state_q   <= ST_IDLE;
                        cur_q     <= nxt_q;
                        busy_q    <= 1'b0;
                        settled_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sw_in   = sw_q;
    assign busy    = busy_q;
    assign settled = settled_q;

endmodule
